// File: rtl/pingpong_sequencer.sv
// pingpong_sequencer: address/enable/done sequencing for the 8x512 ping-pong
// sample buffer. Writer fills the write bank from a non-stallable sample
// stream; reader drains the read bank through a 2-entry output FIFO with
// valid/ready backpressure. Banks swap when goodToGo drops with both dones set.
// Optional feature macro: PINGPONG_DROP_CNT_EN (adds saturating drop_count).
module pingpong_sequencer #(
  parameter int ADDR_W    = 9,
  parameter int DATA_W    = 8,
  parameter int FRAME_LEN = 512
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  output logic [ADDR_W-1:0] w_addr,
  output logic [DATA_W-1:0] w_data,
  output logic              wren,
  output logic              writeDone,
  output logic [ADDR_W-1:0] r_addr,
  input  logic [DATA_W-1:0] r_q,
  output logic              readDone,
  input  logic              goodToGo,
  output logic              m_valid,
  output logic [DATA_W-1:0] m_data,
  input  logic              m_ready,
  output logic              overrun,
  input  logic              overrun_clr,
`ifdef PINGPONG_DROP_CNT_EN
  output logic [15:0]       drop_count,
`endif
  output logic [7:0]        frame_count
);
  // Counters need one extra bit so FRAME_LEN == 2^ADDR_W is representable.
  localparam int               CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] LEN   = CNT_W'(FRAME_LEN);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(FRAME_LEN - 1);

  typedef enum logic {W_FILL, W_DONE} w_state_e;
  typedef enum logic {R_DONE, R_RUN}  r_state_e;

  w_state_e          w_state_q, w_state_d;
  logic [CNT_W-1:0]  wcnt_q, wcnt_d;
  logic [ADDR_W-1:0] w_addr_q, w_addr_d;
  logic [DATA_W-1:0] w_data_q, w_data_d;
  logic              wren_q, wren_d;
  logic              wdone_q, wdone_d;

  r_state_e          r_state_q, r_state_d;
  logic [CNT_W-1:0]  iss_cnt_q, iss_cnt_d;
  logic [CNT_W-1:0]  psh_cnt_q, psh_cnt_d;
  logic              rd_vld_q, rd_vld_d;
  logic [7:0]        frame_cnt_q, frame_cnt_d;

  logic [1:0][DATA_W-1:0] fifo_q, fifo_d;
  logic                   wr_ptr_q, wr_ptr_d;
  logic                   rd_ptr_q, rd_ptr_d;
  logic [1:0]             fifo_cnt_q, fifo_cnt_d;

  logic              ovr_q, ovr_d;

  logic              swp, drop, issue, push, pop;
  logic [2:0]        budget;

  // Swap only when the buffer signals a switch and both halves are finished;
  // a lone goodToGo low (e.g. the power-up switch) is ignored.
  assign swp = ~goodToGo & wdone_q & (r_state_q == R_DONE);

  // Writer: register address/data/enable for each accepted sample, then
  // hold writeDone (one cycle after the final wren) until the swap.
  always_comb begin
    w_state_d = w_state_q;
    wcnt_d    = wcnt_q;
    w_addr_d  = w_addr_q;
    w_data_d  = w_data_q;
    wren_d    = 1'b0;
    drop      = 1'b0;
    case (w_state_q)
      W_FILL: begin
        if (s_valid) begin
          w_addr_d = wcnt_q[ADDR_W-1:0];
          w_data_d = s_data;
          wren_d   = 1'b1;
          wcnt_d   = wcnt_q + CNT_W'(1);
          if (wcnt_q == LAST) w_state_d = W_DONE;
        end
      end
      W_DONE: begin
        drop = s_valid;
        if (swp) begin
          wcnt_d    = '0;
          w_state_d = W_FILL;
        end
      end
      default: w_state_d = W_FILL;
    endcase
    wdone_d = (w_state_q == W_DONE) & ~swp;
  end

  // Reader: r_addr holds the address being read this cycle; a read is issued
  // only if buffered + in-flight words stay within the 2-entry FIFO.
  always_comb begin
    r_state_d   = r_state_q;
    iss_cnt_d   = iss_cnt_q;
    psh_cnt_d   = psh_cnt_q;
    frame_cnt_d = frame_cnt_q;
    pop         = m_valid & m_ready;
    push        = rd_vld_q;
    budget      = {1'b0, fifo_cnt_q} + {2'b00, rd_vld_q};
    issue       = (r_state_q == R_RUN) && (iss_cnt_q != LEN) &&
                  (budget < (3'd2 + {2'b00, pop}));
    if (issue) iss_cnt_d = iss_cnt_q + CNT_W'(1);
    if (push)  psh_cnt_d = psh_cnt_q + CNT_W'(1);
    case (r_state_q)
      R_DONE: begin
        if (swp) begin
          iss_cnt_d   = '0;
          psh_cnt_d   = '0;
          frame_cnt_d = frame_cnt_q + 8'd1;
          r_state_d   = R_RUN;
        end
      end
      R_RUN: begin
        if (push && psh_cnt_q == LAST) r_state_d = R_DONE;
      end
      default: r_state_d = R_DONE;
    endcase
    rd_vld_d = issue;
  end

  // Output FIFO: returning RAM words are pushed; the head drives m_data.
  always_comb begin
    fifo_d = fifo_q;
    if (push) fifo_d[wr_ptr_q] = r_q;
    wr_ptr_d   = wr_ptr_q ^ push;
    rd_ptr_d   = rd_ptr_q ^ pop;
    fifo_cnt_d = fifo_cnt_q + {1'b0, push} - {1'b0, pop};
  end

  // Sticky overrun; a drop in the same cycle as a clear wins.
  always_comb begin
    ovr_d = ovr_q;
    if (drop)             ovr_d = 1'b1;
    else if (overrun_clr) ovr_d = 1'b0;
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      w_state_q   <= W_FILL;
      wcnt_q      <= '0;
      w_addr_q    <= '0;
      w_data_q    <= '0;
      wren_q      <= 1'b0;
      wdone_q     <= 1'b0;
      r_state_q   <= R_DONE;
      iss_cnt_q   <= '0;
      psh_cnt_q   <= '0;
      rd_vld_q    <= 1'b0;
      frame_cnt_q <= '0;
      fifo_q      <= '0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      fifo_cnt_q  <= '0;
      ovr_q       <= 1'b0;
    end else begin
      w_state_q   <= w_state_d;
      wcnt_q      <= wcnt_d;
      w_addr_q    <= w_addr_d;
      w_data_q    <= w_data_d;
      wren_q      <= wren_d;
      wdone_q     <= wdone_d;
      r_state_q   <= r_state_d;
      iss_cnt_q   <= iss_cnt_d;
      psh_cnt_q   <= psh_cnt_d;
      rd_vld_q    <= rd_vld_d;
      frame_cnt_q <= frame_cnt_d;
      fifo_q      <= fifo_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      fifo_cnt_q  <= fifo_cnt_d;
      ovr_q       <= ovr_d;
    end
  end

`ifdef PINGPONG_DROP_CNT_EN
  logic [15:0] drop_cnt_q, drop_cnt_d;

  // Saturating drop counter; an increment beats a same-cycle clear.
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (drop) begin
      if (drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
    end else if (overrun_clr) begin
      drop_cnt_d = '0;
    end
  end

  // Drop counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) drop_cnt_q <= '0;
    else       drop_cnt_q <= drop_cnt_d;
  end

  assign drop_count = drop_cnt_q;
`endif

  assign w_addr      = w_addr_q;
  assign w_data      = w_data_q;
  assign wren        = wren_q;
  assign writeDone   = wdone_q;
  assign r_addr      = iss_cnt_q[ADDR_W-1:0];
  assign readDone    = (r_state_q == R_DONE);
  assign m_valid     = (fifo_cnt_q != 2'd0);
  assign m_data      = fifo_q[rd_ptr_q];
  assign overrun     = ovr_q;
  assign frame_count = frame_cnt_q;

endmodule

// File: tb/tb_pingpong_sequencer.sv
// Bench for pingpong_sequencer: table-driven write vectors plus hand-written
// sequences for swap, drain, backpressure, overrun and reset corner cases.
// A two-bank RAM model stands in for the ping-pong buffer.
module tb_pingpong_sequencer;
  localparam int FLEN = 512;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       s_valid = 1'b0;
  logic [7:0] s_data = 8'h00;
  logic       goodToGo = 1'b1;
  logic       m_ready = 1'b0;
  logic       overrun_clr = 1'b0;
  logic [8:0] w_addr, r_addr;
  logic [7:0] w_data, m_data, frame_count;
  logic [7:0] r_q;
  logic       wren, writeDone, readDone, m_valid, overrun;
`ifdef PINGPONG_DROP_CNT_EN
  logic [15:0] drop_count;
`endif

  int total = 0;
  int bad = 0;

  pingpong_sequencer dut (
    .clk(clk), .reset(reset), .s_valid(s_valid), .s_data(s_data),
    .w_addr(w_addr), .w_data(w_data), .wren(wren), .writeDone(writeDone),
    .r_addr(r_addr), .r_q(r_q), .readDone(readDone), .goodToGo(goodToGo),
    .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready),
    .overrun(overrun), .overrun_clr(overrun_clr),
`ifdef PINGPONG_DROP_CNT_EN
    .drop_count(drop_count),
`endif
    .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  // Ping-pong buffer model: registered read, bank flip on the swap edge.
  logic [7:0] bank [0:1][0:511];
  logic       wsel = 1'b0;
  always @(posedge clk) begin
    if (wren) bank[wsel][w_addr] <= w_data;
    r_q <= bank[~wsel][r_addr];
    if (!goodToGo && writeDone && readDone) wsel <= ~wsel;
  end

  function automatic logic [7:0] dv(input int i, input int mul, input int add);
    return 8'(i * mul + add);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic swap();
    goodToGo = 1'b0;
    step();
    goodToGo = 1'b1;
  endtask

  // Write n consecutive samples; count any cycle whose registered write
  // does not match the expected address/data.
  task automatic write_n(input int n, input int base, input int mul, input int add,
                         output int errs);
    errs = 0;
    for (int i = 0; i < n; i++) begin
      s_valid = 1'b1;
      s_data  = dv(i, mul, add);
      step();
      if (!(wren === 1'b1 && w_addr === 9'(base + i) && w_data === dv(i, mul, add)))
        errs++;
    end
    s_valid = 1'b0;
  endtask

  // Drain one frame, checking order, stall stability and bubbles.
  task automatic drain(input int mul, input int add, input bit rnd,
                       output int errs, output int got, output int bub,
                       output logic rd510, output logic rd511);
    bit         hold;
    logic [7:0] hd;
    errs = 0; got = 0; bub = 0; hold = 0; hd = 8'h00; rd510 = 1'b0; rd511 = 1'b0;
    for (int c = 0; c < 6000 && got < FLEN; c++) begin
      if (hold && !(m_valid === 1'b1 && m_data === hd)) errs++;
      m_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (m_valid) begin
        if (got == FLEN - 2) rd510 = readDone;
        if (got == FLEN - 1) rd511 = readDone;
        if (m_ready) begin
          if (m_data !== dv(got, mul, add)) errs++;
          got++;
          hold = 0;
        end else begin
          hold = 1;
          hd   = m_data;
        end
      end else begin
        hold = 0;
        if (got > 0) bub++;
      end
      step();
    end
    m_ready = 1'b0;
  endtask

  typedef struct {
    logic       sv;
    logic [7:0] sd;
    logic       ew;
    logic [8:0] ea;
    logic [7:0] ed;
  } vec_t;

  vec_t tv [7];

  initial begin
    int   errs, got, bub, werr;
    logic rd510, rd511;

    tv[0] = '{1'b1, 8'hA5, 1'b1, 9'd0, 8'hA5};
    tv[1] = '{1'b0, 8'hFF, 1'b0, 9'd0, 8'h00};
    tv[2] = '{1'b1, 8'h3C, 1'b1, 9'd1, 8'h3C};
    tv[3] = '{1'b1, 8'h7E, 1'b1, 9'd2, 8'h7E};
    tv[4] = '{1'b0, 8'h11, 1'b0, 9'd0, 8'h00};
    tv[5] = '{1'b0, 8'h22, 1'b0, 9'd0, 8'h00};
    tv[6] = '{1'b1, 8'h01, 1'b1, 9'd3, 8'h01};

    // Reset values
    step(); step();
    chk("rst w_addr", w_addr, 0);
    chk("rst w_data", w_data, 0);
    chk("rst wren", wren, 0);
    chk("rst writeDone", writeDone, 0);
    chk("rst r_addr", r_addr, 0);
    chk("rst readDone", readDone, 1);
    chk("rst m_valid", m_valid, 0);
    chk("rst m_data", m_data, 0);
    chk("rst overrun", overrun, 0);
    chk("rst frame_count", frame_count, 0);

    // Power-up switch: goodToGo low in the first cycle after reset
    reset = 1'b0;
    goodToGo = 1'b0;
    step();
    goodToGo = 1'b1;
    step();
    chk("pwrup frame_count", frame_count, 0);
    chk("pwrup readDone", readDone, 1);
    chk("pwrup m_valid", m_valid, 0);

    // Table-driven single-cycle write vectors
    for (int k = 0; k < 7; k++) begin
      s_valid = tv[k].sv;
      s_data  = tv[k].sd;
      step();
      chk($sformatf("vec%0d wren", k), wren, tv[k].ew);
      if (tv[k].ew) begin
        chk($sformatf("vec%0d w_addr", k), w_addr, tv[k].ea);
        chk($sformatf("vec%0d w_data", k), w_data, tv[k].ed);
      end
      chk($sformatf("vec%0d writeDone", k), writeDone, 0);
    end
    s_valid = 1'b0;

    // Reset mid-frame after 100 samples
    write_n(96, 4, 1, 4, errs);
    chk("prefill writes", errs, 0);
    reset = 1'b1;
    #2;
    chk("midrst wren", wren, 0);
    chk("midrst w_addr", w_addr, 0);
    chk("midrst w_data", w_data, 0);
    chk("midrst writeDone", writeDone, 0);
    chk("midrst readDone", readDone, 1);
    step();
    reset = 1'b0;
    step();

    // Fill: 512 samples of i[7:0]; first lands at w_addr 0
    write_n(FLEN, 0, 1, 0, errs);
    chk("fill writes", errs, 0);
    chk("fill writeDone in last wren cycle", writeDone, 0);
    step();
    chk("fill wren after", wren, 0);
    chk("fill writeDone", writeDone, 1);

    // Swap and in-order drain at one word per cycle
    m_ready = 1'b1;
    swap();
    chk("swap1 writeDone", writeDone, 0);
    chk("swap1 readDone", readDone, 0);
    chk("swap1 frame_count", frame_count, 1);
    chk("lat E0 m_valid", m_valid, 0);
    step();
    chk("lat E1 m_valid", m_valid, 0);
    step();
    chk("lat E2 m_valid", m_valid, 1);
    chk("lat E2 m_data", m_data, 0);
    drain(1, 0, 1'b0, errs, got, bub, rd510, rd511);
    chk("fill drain count", got, FLEN);
    chk("fill drain data", errs, 0);
    chk("fill drain bubbles", bub, 0);
    chk("readDone at word 510", rd510, 0);
    chk("readDone at word 511", rd511, 1);
    chk("fill readDone end", readDone, 1);

    // Backpressure: random m_ready
    write_n(FLEN, 0, 7, 3, errs);
    chk("bp writes", errs, 0);
    step();
    swap();
    chk("bp frame_count", frame_count, 2);
    drain(7, 3, 1'b1, errs, got, bub, rd510, rd511);
    chk("bp drain count", got, FLEN);
    chk("bp drain data/stable", errs, 0);
    step(); step(); step();
    chk("bp no extra m_valid", m_valid, 0);

    // Overrun: reader stalled through a second full frame
    write_n(FLEN, 0, 3, 11, errs);
    chk("ovr frame3 writes", errs, 0);
    step();
    swap();
    chk("ovr frame_count", frame_count, 3);
    write_n(FLEN, 0, 5, 1, errs);
    chk("ovr frame4 writes", errs, 0);
    chk("stall r_addr", r_addr, 2);
    chk("stall m_valid", m_valid, 1);
    chk("stall m_data", m_data, dv(0, 3, 11));
    step();
    chk("ovr writeDone", writeDone, 1);
    chk("ovr readDone", readDone, 0);
    chk("ovr flag before drops", overrun, 0);
    werr = 0;
    for (int k = 0; k < 10; k++) begin
      s_valid = 1'b1;
      s_data  = 8'(k);
      step();
      if (wren !== 1'b0) werr++;
    end
    s_valid = 1'b0;
    chk("ovr wren stays 0", werr, 0);
    chk("ovr flag", overrun, 1);
`ifdef PINGPONG_DROP_CNT_EN
    chk("ovr drop_count", drop_count, 10);
`endif
    overrun_clr = 1'b1;
    s_valid = 1'b1;
    step();
    overrun_clr = 1'b0;
    s_valid = 1'b0;
    chk("ovr clr+drop", overrun, 1);
`ifdef PINGPONG_DROP_CNT_EN
    chk("ovr clr+drop count", drop_count, 11);
`endif
    overrun_clr = 1'b1;
    step();
    overrun_clr = 1'b0;
    chk("ovr cleared", overrun, 0);
`ifdef PINGPONG_DROP_CNT_EN
    chk("ovr count cleared", drop_count, 0);
`endif
    drain(3, 11, 1'b0, errs, got, bub, rd510, rd511);
    chk("ovr drain count", got, FLEN);
    chk("ovr drain data", errs, 0);
    chk("ovr readDone", readDone, 1);

    // Sample during the swap cycle is dropped
    s_valid  = 1'b1;
    s_data   = 8'h55;
    goodToGo = 1'b0;
    step();
    goodToGo = 1'b1;
    chk("swpcyc overrun", overrun, 1);
    chk("swpcyc wren", wren, 0);
    chk("swpcyc writeDone", writeDone, 0);
    chk("swpcyc frame_count", frame_count, 4);
    s_data = 8'h66;
    step();
    s_valid = 1'b0;
    chk("post-swap wren", wren, 1);
    chk("post-swap w_addr", w_addr, 0);
    chk("post-swap w_data", w_data, 8'h66);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
